// File: rtl/taxi_fare_meter_if.sv
// Trip-control and fare-readout bundle shared by the meter and whatever drives it.
interface taxi_fare_meter_if #(
    parameter int W = 32
);
    logic         start;
    logic         stop;
    logic         dist_pulse;
    logic         low_speed;
    logic         night;
    logic [W-1:0] distance;
    logic [W-1:0] wait_units;
    logic [W-1:0] fare;
    logic [1:0]   state;
    logic         fare_valid;

    modport master (
        output start, stop, dist_pulse, low_speed, night,
        input  distance, wait_units, fare, state, fare_valid
    );

    modport slave (
        input  start, stop, dist_pulse, low_speed, night,
        output distance, wait_units, fare, state, fare_valid
    );
endinterface

// File: rtl/taxi_fare_meter.sv
// Taxi fare meter: flag-fall fare plus tiered per-step distance charge and
// low-speed waiting charge, with a RUN/HOLD/IDLE trip state machine.
module taxi_fare_meter #(
    parameter int W           = 32,
    parameter int BASE_FARE   = 130,
    parameter int BASE_DIST   = 3000,
    parameter int STEP_DIST   = 1000,
    parameter int RATE1       = 23,
    parameter int TIER2_DIST  = 10000,
    parameter int RATE2       = 33,
    parameter int NBASE_FARE  = 160,
    parameter int NRATE1      = 28,
    parameter int NRATE2      = 40,
    parameter int WAIT_CYCLES = 60,
    parameter int WAIT_RATE   = 23
) (
    input logic             clk,
    input logic             rst_n,
    taxi_fare_meter_if.slave bus
);

    localparam int STEP_W = $clog2(STEP_DIST + 1);
    localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);

    localparam logic [W-1:0] DAY_BASE   = W'(BASE_FARE);
    localparam logic [W-1:0] NIGHT_BASE = W'(NBASE_FARE);
    localparam logic [W-1:0] DAY_R1     = W'(RATE1);
    localparam logic [W-1:0] DAY_R2     = W'(RATE2);
    localparam logic [W-1:0] NIGHT_R1   = W'(NRATE1);
    localparam logic [W-1:0] NIGHT_R2   = W'(NRATE2);
    localparam logic [W-1:0] WAIT_CHG   = W'(WAIT_RATE);
    localparam logic [W-1:0] FREE_DIST  = W'(BASE_DIST);
    localparam logic [W-1:0] TIER2_EDGE = W'(TIER2_DIST);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIST - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_r;
    logic                night_r;
    logic [W-1:0]        distance_r;
    logic [W-1:0]        wait_units_r;
    logic [W-1:0]        fare_r;
    logic                fare_valid_r;
    logic [STEP_W-1:0]   step_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [W-1:0]        dist_fare;
    logic [W-1:0]        wait_fare;

    logic [W-1:0]        dist_next;
    logic [W-1:0]        step_rate;
    logic [W-1:0]        trip_base;
    logic [W-1:0]        start_base;
    logic [W-1:0]        fare_sum;

    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    // Derived values: next distance, rate for a step ending at that distance, and the running total
    always_comb begin
        dist_next  = (distance_r == {W{1'b1}}) ? distance_r : distance_r + W'(1);
        if (night_r)
            step_rate = (dist_next <= TIER2_EDGE) ? NIGHT_R1 : NIGHT_R2;
        else
            step_rate = (dist_next <= TIER2_EDGE) ? DAY_R1 : DAY_R2;
        trip_base  = night_r ? NIGHT_BASE : DAY_BASE;
        start_base = bus.night ? NIGHT_BASE : DAY_BASE;
        fare_sum   = sat_add(sat_add(trip_base, dist_fare), wait_fare);
    end

    // Trip state machine with all counters, accumulators and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            night_r      <= 1'b0;
            distance_r   <= '0;
            wait_units_r <= '0;
            fare_r       <= '0;
            fare_valid_r <= 1'b0;
            step_cnt     <= '0;
            wait_cnt     <= '0;
            dist_fare    <= '0;
            wait_fare    <= '0;
        end else begin
            case (state_r)
                IDLE, HOLD: begin
                    // IDLE is always all-zero, so a stop there is a harmless re-clear
                    if (bus.start) begin
                        state_r      <= RUN;
                        night_r      <= bus.night;
                        distance_r   <= '0;
                        wait_units_r <= '0;
                        fare_r       <= start_base;
                        fare_valid_r <= 1'b0;
                        step_cnt     <= '0;
                        wait_cnt     <= '0;
                        dist_fare    <= '0;
                        wait_fare    <= '0;
                    end else if (bus.stop) begin
                        state_r      <= IDLE;
                        night_r      <= 1'b0;
                        distance_r   <= '0;
                        wait_units_r <= '0;
                        fare_r       <= '0;
                        fare_valid_r <= 1'b0;
                        step_cnt     <= '0;
                        wait_cnt     <= '0;
                        dist_fare    <= '0;
                        wait_fare    <= '0;
                    end
                end
                RUN: begin
                    // The fare register always settles from the accumulators, so the
                    // held fare matches the frozen counters even if a step just landed
                    fare_r <= fare_sum;
                    if (bus.stop) begin
                        state_r      <= HOLD;
                        fare_valid_r <= 1'b1;
                    end else begin
                        if (bus.dist_pulse) begin
                            distance_r <= dist_next;
                            if (distance_r >= FREE_DIST) begin
                                if (step_cnt == STEP_LAST) begin
                                    step_cnt  <= '0;
                                    dist_fare <= sat_add(dist_fare, step_rate);
                                end else begin
                                    step_cnt <= step_cnt + STEP_W'(1);
                                end
                            end
                        end
                        if (bus.low_speed) begin
                            if (wait_cnt == WAIT_LAST) begin
                                wait_cnt     <= '0;
                                wait_units_r <= sat_add(wait_units_r, W'(1));
                                wait_fare    <= sat_add(wait_fare, WAIT_CHG);
                            end else begin
                                wait_cnt <= wait_cnt + WAIT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    night_r      <= 1'b0;
                    distance_r   <= '0;
                    wait_units_r <= '0;
                    fare_r       <= '0;
                    fare_valid_r <= 1'b0;
                    step_cnt     <= '0;
                    wait_cnt     <= '0;
                    dist_fare    <= '0;
                    wait_fare    <= '0;
                end
            endcase
        end
    end

    assign bus.distance   = distance_r;
    assign bus.wait_units = wait_units_r;
    assign bus.fare       = fare_r;
    assign bus.state      = state_r;
    assign bus.fare_valid = fare_valid_r;

endmodule

// File: doc/taxi_fare_meter.md
TAXI_FARE_METER -- requirements
Module: taxi_fare_meter

Interface
REQ-001 SHALL have parameters: W=32, fare/counter width; BASE_FARE=130, flag-fall fare in 0.1 units; BASE_DIST=3000, metres covered by flag-fall; STEP_DIST=1000, metres per charged step; RATE1=23, fare per step up to TIER2_DIST; TIER2_DIST=10000, metres where tier 2 starts; RATE2=33, fare per step beyond TIER2_DIST; NBASE_FARE=160, NRATE1=28, NRATE2=40, night equivalents; WAIT_CYCLES=60, low-speed clocks per wait unit; WAIT_RATE=23, fare per wait unit.
REQ-002 SHALL have ports (name direction width meaning): clk input 1 system clock, rising edge; rst_n input 1 reset.
REQ-003 SHALL have ports: start input 1 begin-trip pulse; stop input 1 end-trip/clear pulse; dist_pulse input 1 one metre travelled; low_speed input 1 level, vehicle slow/stationary; night input 1 tariff select, sampled on trip start.
REQ-004 SHALL have ports: distance output W metres this trip; wait_units output W completed wait units; fare output W current fare; state output 2 FSM state; fare_valid output 1 final fare held.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-006 SHALL implement FSM IDLE=0, RUN=1, HOLD=2; code 3 unreachable, recovers to IDLE next clock.
REQ-007 SHALL, in IDLE, on start: enter RUN; clear distance, wait_units, step/wait counters, accumulated fares; latch night as tariff; stop ignored.
REQ-008 SHALL, in RUN, on stop: enter HOLD, freeze all counters and fare, assert fare_valid; stop wins over simultaneous start.
REQ-009 SHALL, in HOLD: on start begin new trip exactly as REQ-007 (fare_valid low); on stop return to IDLE clearing all outputs; start wins if both.
REQ-010 SHALL, in RUN, increment distance on each clock with dist_pulse=1; pulses outside RUN ignored.
REQ-011 SHALL keep a metre-in-step counter active once distance > BASE_DIST; each time it completes STEP_DIST metres it wraps to 0 and adds the tariff rate to distance fare.
REQ-012 SHALL use RATE1/NRATE1 for steps ending at or below TIER2_DIST, RATE2/NRATE2 for steps ending above; no divider or multiplier in the fare path.
REQ-013 SHALL, in RUN with low_speed=1, count clocks; at WAIT_CYCLES-1 wrap to 0, increment wait_units, add WAIT_RATE to wait fare; partial count persists across low_speed gaps.
REQ-014 SHALL count dist_pulse and low_speed in the same cycle independently.
REQ-015 SHALL register fare = base(tariff) + distance fare + wait fare, updated the clock after the counter edge (1-cycle latency); fare = base while in RUN before any step.
REQ-016 SHALL saturate distance, wait_units, fare at 2^W-1; no wrap.
REQ-017 SHALL drive state as the registered FSM code; fare_valid high only in HOLD.

Reset
REQ-018 SHALL, when rst_n=0, immediately force IDLE, all outputs 0, all internal counters and fare accumulators 0, regardless of clk.
REQ-019 SHALL abandon a trip in progress on reset mid-RUN; no fare retained.
REQ-020 SHALL leave reset on first rising clk with rst_n=1; start on that edge is accepted.

Verification
REQ-021 SHALL cover: start, 3000 dist_pulse, stop -> HOLD, distance=3000, fare=130, fare_valid=1.
REQ-022 SHALL cover: 3999 pulses -> fare 130; 4000th pulse -> fare 153 one clock later.
REQ-023 SHALL cover: 12000 pulses day tariff -> fare 130+7*23+2*33=357; night=1 at start, 5000 pulses -> 160+2*28=216 (night toggled mid-trip: no change).
REQ-024 SHALL cover: low_speed held 120 clocks, no pulses -> wait_units=2, fare=176; 59 clocks then gap then 1 clock -> wait_units=1.
REQ-025 SHALL cover: rst_n low mid-RUN between clocks -> outputs 0, state 0 immediately; start and stop same cycle in RUN -> HOLD, in HOLD -> new RUN with fare 130.
